// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the 512 x 16 instruction memory.
// Takes a byte stream (LEN_LO, LEN_HI, then N little-endian words),
// writes word k to address k, and keeps the core in reset until a
// complete image is in memory.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t state_q, state_d;

  logic [9:0]        wordIdx_q;
  logic [9:0]        wordCnt_q;
  logic [7:0]        lenLo_q;
  logic [7:0]        dataLo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              inReady_q, inReady_d;
  logic              imemWe_q, imemWe_d;
  logic [ADDR_W-1:0] imemAddr_q, imemAddr_d;
  logic [DATA_W-1:0] imemWdata_q, imemWdata_d;
  logic              cpuReset_q, cpuReset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              startLoad;
  logic [15:0]       lenFull;
  logic              lenBad;
  logic              lastWord;

  // inReady_q always mirrors the state, so it qualifies the byte transfer
  assign accept    = in_valid && inReady_q;
  assign startLoad = load_req &&
                     ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign lenFull   = {in_data, lenLo_q};
  assign lenBad    = (lenFull == 16'd0) || (lenFull > DEPTH16);
  assign lastWord  = (10'(wordIdx_q + 10'd1) == wordCnt_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every byte-consuming state advances only on accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_d = lenBad ? S_ERR : S_DATA_LO;
      end
      S_DATA_LO: begin
        if (accept) state_d = S_DATA_HI;
      end
      S_DATA_HI: begin
        if (accept) begin
          if (!lastWord) begin
            state_d = S_DATA_LO;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_DRAIN : S_ERR;
      end
`endif
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (load_req) state_d = S_LEN_LO;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the next state
  always_comb begin
    inReady_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpuReset_d  = (state_d != S_DONE);
    imemWe_d    = 1'b0;
    imemAddr_d  = imemAddr_q;
    imemWdata_d = imemWdata_q;
    case (state_d)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: begin
        inReady_d = 1'b1;
        busy_d    = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        inReady_d = 1'b1;
        busy_d    = 1'b1;
      end
`endif
      S_DRAIN: begin
        busy_d = 1'b1;
      end
      default: begin
        inReady_d = 1'b0;
      end
    endcase
    if ((state_q == S_DATA_HI) && accept) begin
      imemWe_d    = 1'b1;
      imemAddr_d  = wordIdx_q[ADDR_W-1:0];
      imemWdata_d = DATA_W'({in_data, dataLo_q});
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      inReady_q   <= 1'b0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuReset_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      inReady_q   <= inReady_d;
      imemWe_q    <= imemWe_d;
      imemAddr_q  <= imemAddr_d;
      imemWdata_q <= imemWdata_d;
      cpuReset_q  <= cpuReset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Datapath: length capture, low-byte holding, word index and running checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      wordIdx_q <= '0;
      wordCnt_q <= '0;
      lenLo_q   <= '0;
      dataLo_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      if (startLoad) begin
        wordIdx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q    <= '0;
`endif
      end
      if (accept) begin
        case (state_q)
          S_LEN_LO: begin
            lenLo_q <= in_data;
          end
          S_LEN_HI: begin
            wordCnt_q <= lenFull[9:0];
          end
          S_DATA_LO: begin
            dataLo_q <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ in_data;
`endif
          end
          S_DATA_HI: begin
            wordIdx_q <= 10'(wordIdx_q + 10'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_q ^ in_data;
`endif
          end
          default: begin
            lenLo_q <= lenLo_q;
          end
        endcase
      end
    end
  end

  assign in_ready   = inReady_q;
  assign imem_we    = imemWe_q;
  assign imem_addr  = imemAddr_q;
  assign imem_wdata = imemWdata_q;
  assign cpu_reset  = cpuReset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of whole-image loads plus hand-written
// sequences for reset mid-load, a full 512-word image and restart from DONE.
// Expected writes go into a queue as bytes are driven and are popped when
// imem_we is observed.
`timescale 1ns/1ps

module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writesSeen = 0;
  int lastWeCyc = 0;
  logic [8:0] lastAddr = '0;
  logic prevCpuReset = 1'b1;

  logic [24:0] sbQ[$];
  logic [15:0] img[512];
  logic [15:0] tbMem[512];

  typedef struct {
    int unsigned len;
    bit          gaps;
    bit          badCsum;
    bit          planWords;
    bit          expLenErr;
    bit          expDone;
    bit          expErr;
    int unsigned expWrites;
  } vec_t;

  vec_t vecs[7];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory model: writes on the edge after the imem_we pulse
  always @(posedge clk) begin
    if (imem_we) tbMem[imem_addr] <= imem_wdata;
  end

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Write monitor: pop the scoreboard and check the core-release timing
  always @(negedge clk) begin
    logic [24:0] e;
    if (imem_we) begin
      writesSeen++;
      lastAddr  = imem_addr;
      lastWeCyc = cyc;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h expected none",
                 imem_addr, imem_wdata);
      end else begin
        e = sbQ.pop_front();
        checkOutput("writeAddr", 32'(imem_addr), 32'(e[24:16]));
        checkOutput("writeData", 32'(imem_wdata), 32'(e[15:0]));
      end
    end
    if (prevCpuReset && !cpu_reset)
      checkOutput("cpuResetFallDelay", 32'(cyc - lastWeCyc), 32'(1 + CS));
    prevCpuReset = cpu_reset;
  end

  task automatic pulseLoad();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps, output bit ok);
    int n;
    ok = 1'b0;
    if (gaps) begin
      n = $urandom_range(0, 3);
      in_valid = 1'b0;
      for (int g = 0; g < n; g++) begin
        load_req = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        load_req = 1'b0;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL byteTimeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  // One complete load; returns the edges of first accept and of done/error
  task automatic applyStimulus(input int unsigned len, input bit gaps, input bit badCsum,
                               input bit expLenErr, output int firstEdge, output int endEdge);
    bit ok;
    logic [15:0] L;
    logic [15:0] w;
    logic [7:0]  cs;
    L = len[15:0];
    cs = 8'h00;
    firstEdge = 0;
    endEdge = 0;
    for (int i = 0; i < 512; i++) tbMem[i] = 16'hDEAD;
    pulseLoad();
    checkOutput("startInReady", 32'(in_ready), 32'd1);
    checkOutput("startBusy", 32'(busy), 32'd1);
    checkOutput("startDoneClr", 32'(done), 32'd0);
    checkOutput("startErrClr", 32'(error), 32'd0);
    checkOutput("startCpuReset", 32'(cpu_reset), 32'd1);
    sendByte(L[7:0], gaps, ok);
    if (!ok) return;
    firstEdge = cyc;
    sendByte(L[15:8], gaps, ok);
    if (!ok) return;
    if (expLenErr) begin
      in_valid = 1'b0;
      checkOutput("lenErrInReady", 32'(in_ready), 32'd0);
    end else begin
      for (int k = 0; k < int'(len); k++) begin
        w = img[k];
        cs = cs ^ w[7:0] ^ w[15:8];
        sendByte(w[7:0], gaps, ok);
        if (!ok) return;
        sbQ.push_back({9'(k), w});
        sendByte(w[15:8], gaps, ok);
        if (!ok) return;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendByte(badCsum ? ~cs : cs, gaps, ok);
      if (!ok) return;
`endif
      in_valid = 1'b0;
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done || error) begin
        endEdge = cyc;
        break;
      end
    end
    if (endEdge == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL endTimeout: got done 0 error 0 expected one of them set");
    end
  endtask

  function automatic int imageMismatches(input int unsigned len);
    int m = 0;
    for (int k = 0; k < int'(len); k++)
      if (tbMem[k] !== img[k]) m++;
    return m;
  endfunction

  initial begin
    int fe, ee;
    bit ok;

    vecs[0] = '{len: 3,      gaps: 0, badCsum: 0, planWords: 1, expLenErr: 0, expDone: 1, expErr: 0, expWrites: 3};
    vecs[1] = '{len: 0,      gaps: 0, badCsum: 0, planWords: 0, expLenErr: 1, expDone: 0, expErr: 1, expWrites: 0};
    vecs[2] = '{len: 513,    gaps: 0, badCsum: 0, planWords: 0, expLenErr: 1, expDone: 0, expErr: 1, expWrites: 0};
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[3] = '{len: 3,      gaps: 0, badCsum: 1, planWords: 1, expLenErr: 0, expDone: 0, expErr: 1, expWrites: 3};
`else
    vecs[3] = '{len: 3,      gaps: 0, badCsum: 1, planWords: 1, expLenErr: 0, expDone: 1, expErr: 0, expWrites: 3};
`endif
    vecs[4] = '{len: 16,     gaps: 1, badCsum: 0, planWords: 0, expLenErr: 0, expDone: 1, expErr: 0, expWrites: 16};
    vecs[5] = '{len: 16'hFFFF, gaps: 0, badCsum: 0, planWords: 0, expLenErr: 1, expDone: 0, expErr: 1, expWrites: 0};
    vecs[6] = '{len: 40,     gaps: 0, badCsum: 0, planWords: 0, expLenErr: 0, expDone: 1, expErr: 0, expWrites: 40};

    reset = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstWe", 32'(imem_we), 32'd0);
    checkOutput("rstAddr", 32'(imem_addr), 32'd0);
    checkOutput("rstWdata", 32'(imem_wdata), 32'd0);
    checkOutput("rstCpuReset", 32'(cpu_reset), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstError", 32'(error), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].planWords) begin
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        img[2] = 16'h0001;
      end else begin
        for (int k = 0; k < 512; k++) img[k] = 16'($urandom);
      end
      writesSeen = 0;
      applyStimulus(vecs[v].len, vecs[v].gaps, vecs[v].badCsum, vecs[v].expLenErr, fe, ee);
      repeat (2) @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.writes", v), 32'(writesSeen), 32'(vecs[v].expWrites));
      checkOutput($sformatf("v%0d.done", v), 32'(done), 32'(vecs[v].expDone));
      checkOutput($sformatf("v%0d.error", v), 32'(error), 32'(vecs[v].expErr));
      checkOutput($sformatf("v%0d.cpuReset", v), 32'(cpu_reset), 32'(!vecs[v].expDone));
      checkOutput($sformatf("v%0d.busy", v), 32'(busy), 32'd0);
      checkOutput($sformatf("v%0d.inReady", v), 32'(in_ready), 32'd0);
      checkOutput($sformatf("v%0d.pending", v), 32'(sbQ.size()), 32'd0);
      if (!vecs[v].expLenErr)
        checkOutput($sformatf("v%0d.image", v), 32'(imageMismatches(vecs[v].len)), 32'd0);
      if (!vecs[v].gaps && vecs[v].expDone)
        checkOutput($sformatf("v%0d.latency", v), 32'(ee - fe), 32'(2 + 2 * vecs[v].len + CS));
    end

    // Reset after five bytes of a four-word image
    for (int k = 0; k < 512; k++) img[k] = 16'($urandom);
    writesSeen = 0;
    pulseLoad();
    sendByte(8'h04, 1'b0, ok);
    sendByte(8'h00, 1'b0, ok);
    sendByte(img[0][7:0], 1'b0, ok);
    sbQ.push_back({9'd0, img[0]});
    sendByte(img[0][15:8], 1'b0, ok);
    sendByte(img[1][7:0], 1'b0, ok);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRstInReady", 32'(in_ready), 32'd0);
    checkOutput("midRstCpuReset", 32'(cpu_reset), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstWe", 32'(imem_we), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midRstWrites", 32'(writesSeen), 32'd1);
    checkOutput("midRstWord0Kept", 32'(tbMem[0]), 32'(img[0]));

    // Full-depth image
    writesSeen = 0;
    applyStimulus(512, 1'b0, 1'b0, 1'b0, fe, ee);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("fullWrites", 32'(writesSeen), 32'd512);
    checkOutput("fullLastAddr", 32'(lastAddr), 32'h1FF);
    checkOutput("fullDone", 32'(done), 32'd1);
    checkOutput("fullImage", 32'(imageMismatches(512)), 32'd0);

    // Restart from DONE with a single 0xFFFF word
    img[0] = 16'hFFFF;
    writesSeen = 0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, fe, ee);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("oneWrites", 32'(writesSeen), 32'd1);
    checkOutput("oneWord", 32'(tbMem[0]), 32'hFFFF);
    checkOutput("oneDone", 32'(done), 32'd1);
    checkOutput("oneCpuReset", 32'(cpu_reset), 32'd0);
    checkOutput("oneLatency", 32'(ee - fe), 32'(4 + CS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
